// File: rtl/boot_dl_sink.sv
// Boot download sink: captures dn_* byte strobes into a FIFO, commits them to memory
// through a req/ack port, and releases the CPU with a start address once drained.
module boot_dl_sink #(
    parameter int unsigned         ADDR_W     = 16,
    parameter int unsigned         MEM_AW     = 24,
    parameter logic [MEM_AW-1:0]   BASE_ADDR  = 24'h000000,
    parameter int unsigned         FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dn_go,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [7:0]        dn_data,
    input  logic              execute_enable,
    input  logic [ADDR_W-1:0] execute_addr,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    output logic              cpu_hold,
    output logic              exec_load,
    output logic [ADDR_W-1:0] exec_pc,
    output logic              overflow,
    output logic [15:0]       byte_count
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_EXEC
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fill;

    logic dn_wr_d, dn_go_d, pending;

    logic go_rise, go_fall, wr_rise;
    logic fifo_empty, fifo_full;
    logic push_req, push, pop, drop, issue, exec_seen;
    logic [ADDR_W-1:0] issue_addr;
    logic [7:0]        issue_data;

    logic hold_set, hold_clr, load_exec, clear_stream;

    always_comb begin
        go_rise    = dn_go & ~dn_go_d;
        go_fall    = ~dn_go & dn_go_d;
        wr_rise    = dn_wr & ~dn_wr_d;
        fifo_empty = (fill == '0);
        fifo_full  = (fill == (PW+1)'(FIFO_DEPTH));
        pop        = mem_req & mem_ack;
        push_req   = (state == S_LOAD) & wr_rise;
        push       = push_req & (~fifo_full | pop);
        drop       = push_req & fifo_full & ~pop;
        exec_seen  = execute_enable & ((state == S_LOAD) | (state == S_DRAIN));
        // An empty FIFO forwards the byte being pushed so the request starts a cycle earlier.
        issue      = ~mem_req & (~fifo_empty | push);
        issue_addr = fifo_empty ? dn_addr : fifo_addr[rd_ptr];
        issue_data = fifo_empty ? dn_data : fifo_data[rd_ptr];
    end

    always_comb begin
        state_nx     = state;
        hold_set     = 1'b0;
        hold_clr     = 1'b0;
        load_exec    = 1'b0;
        clear_stream = 1'b0;
        case (state)
            S_IDLE: begin
                if (go_rise) begin
                    state_nx     = S_LOAD;
                    hold_set     = 1'b1;
                    clear_stream = 1'b1;
                end
            end
            S_LOAD: begin
                if (go_fall) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (go_rise) begin
                    state_nx     = S_LOAD;
                    hold_set     = 1'b1;
                    clear_stream = 1'b1;
                end else if (fifo_empty && !mem_req) begin
                    if (pending || exec_seen) begin
                        state_nx  = S_EXEC;
                        load_exec = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                        hold_clr = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (go_rise) begin
                    state_nx     = S_LOAD;
                    hold_set     = 1'b1;
                    clear_stream = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                    hold_clr = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            dn_wr_d    <= 1'b0;
            dn_go_d    <= 1'b0;
            pending    <= 1'b0;
            cpu_hold   <= 1'b0;
            exec_load  <= 1'b0;
            exec_pc    <= '0;
            overflow   <= 1'b0;
            byte_count <= '0;
        end else begin
            state     <= state_nx;
            dn_wr_d   <= dn_wr;
            dn_go_d   <= dn_go;
            exec_load <= load_exec;
            if (hold_set) begin
                cpu_hold <= 1'b1;
            end else if (hold_clr) begin
                cpu_hold <= 1'b0;
            end
            if (clear_stream || state == S_EXEC) begin
                pending <= 1'b0;
            end else if (exec_seen) begin
                pending <= 1'b1;
            end
            if (exec_seen) begin
                exec_pc <= execute_addr;
            end
            if (clear_stream) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
            if (clear_stream) begin
                byte_count <= '0;
            end else if (pop) begin
                byte_count <= byte_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fill <= fill + (PW+1)'(1);
                2'b01:   fill <= fill - (PW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dn_addr;
            fifo_data[wr_ptr] <= dn_data;
        end
    end

    // Address/data only change when a new request is issued, so they stay stable under req.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (pop) begin
            mem_req <= 1'b0;
        end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= BASE_ADDR + MEM_AW'(issue_addr);
            mem_din  <= issue_data;
        end
    end

endmodule

// File: doc/boot_dl_sink.md
# boot_dl_sink

Receiving end of the boot download stream that the top level produces after every reset (dn_go / dn_wr / dn_addr / dn_data, then execute_enable / execute_addr). Captures each byte on the strobe edge, buffers it in a small FIFO, and writes it to the memory arbiter through a req/ack port. Holds the CPU while loading, then hands it the start address only after the last byte is committed to memory. Sits inside pcw_core, between the dn_* inputs and the SDRAM arbiter.

## Interface
- ADDR_W, 16, width of dn_addr / execute_addr / exec_pc
- MEM_AW, 24, width of mem_addr
- BASE_ADDR, 24'h000000, memory offset added to dn_addr
- FIFO_DEPTH, 4, entries; power of two, ≥2

- clk_sys  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- dn_go  in  1  download window; level
- dn_wr  in  1  byte strobe; level, held high for several clocks per byte
- dn_addr  in  ADDR_W  byte address; valid while dn_wr high
- dn_data  in  8  byte data; valid while dn_wr high
- execute_enable  in  1  start request pulse
- execute_addr  in  ADDR_W  start PC; sampled with execute_enable
- mem_req  out  1  write request; held until mem_ack
- mem_addr  out  MEM_AW  BASE_ADDR + zero-extended dn_addr
- mem_din  out  8  write data
- mem_ack  in  1  one-cycle acknowledge; ignored when mem_req low
- cpu_hold  out  1  keep CPU halted
- exec_load  out  1  one-cycle pulse: load exec_pc into CPU PC
- exec_pc  out  ADDR_W  start address
- overflow  out  1  sticky: a byte was dropped
- byte_count  out  16  bytes committed (acked) since last dn_go rise; wraps

## Operation
- Reset: every output 0, FIFO empty, state IDLE, pending-exec flag clear, dn_wr/dn_go history registers 0.
- States: IDLE, LOAD, DRAIN, EXEC.
- IDLE: dn_go rising edge → LOAD; cpu_hold=1, overflow=0, byte_count=0.
- LOAD: dn_wr rising edge (high now, low previous cycle) pushes {dn_addr,dn_data}. Push while full and no pop the same cycle → byte dropped, overflow=1. Push and pop in the same cycle when full → push accepted.
- dn_go falling edge in LOAD → DRAIN. execute_enable seen in LOAD or DRAIN sets the pending flag and latches execute_addr into exec_pc (last one wins).
- Writer (independent of state): FIFO non-empty and mem_req low and no ack this cycle → assert mem_req with head entry. On mem_ack: pop, byte_count+1, mem_req low next cycle (minimum one idle cycle between requests).
- DRAIN: FIFO empty and mem_req low → pending set: EXEC; else IDLE with cpu_hold=0.
- EXEC: exec_load=1 for exactly one cycle; next cycle cpu_hold=0, pending clear, → IDLE.
- dn_go rising edge in DRAIN/EXEC: treated as new download → LOAD, pending cleared, FIFO contents retained and still written.
- execute_enable in IDLE: ignored.
- Address arithmetic: mem_addr = BASE_ADDR + {0,dn_addr}, modulo 2^MEM_AW.

## Timing
- dn_wr edge at cycle N → entry written end of N → mem_req high at N+1 (FIFO previously empty, writer idle).
- mem_ack at cycle M → mem_req low M+1 → next mem_req no earlier than M+2.
- mem_addr/mem_din stable while mem_req high.
- Last ack at cycle L, pending set, dn_go already low → EXEC entered L+1 or later, exec_load high one cycle, cpu_hold low the cycle after.
- overflow sets the cycle after the dropped push; cleared only by reset or dn_go rise.
- Reset mid-transfer: outstanding mem_req dropped next cycle, FIFO flushed, no exec_load.

## Test plan
- Single byte dn_addr=0x0010, dn_data=0xA5, mem_ack 3 cycles after req → one request, mem_addr=0x000010, mem_din=0xA5, byte_count=1.
- 276-byte stream (addr 0..275, one byte per 16 clocks), ack latency 2, then dn_go low and execute_enable with execute_addr=0x0000 → 276 writes in order, exec_load once with exec_pc=0x0000 after last ack, cpu_hold then 0.
- mem_ack withheld, 6 strobes with FIFO_DEPTH=4 → 4 queued, overflow=1, released acks yield exactly 4 writes (first 4 addresses).
- execute_enable while 3 entries pending → exec_load only after third ack, not before.
- reset asserted while mem_req high with 2 queued → next cycle all outputs 0, no further writes, no exec_load.
- Second dn_go rise after an overflow → overflow=0, byte_count=0, new stream written correctly; BASE_ADDR=0x100000 shifts mem_addr accordingly.
